// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared constants and byte-select helpers for the return-address stack
package ras_pkg;

  localparam int AW_DEF = 16;
  localparam int BW_DEF = 8;

  // Sender FSM encoding
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] SEND_LO = 2'b01;
  localparam logic [1:0] SEND_HI = 2'b10;

  // Low byte of a 16-bit address (sent first, with the load strobe)
  function automatic logic [BW_DEF-1:0] lo_byte(input logic [AW_DEF-1:0] a);
    return a[BW_DEF-1:0];
  endfunction

  // High byte of a 16-bit address (sent second)
  function automatic logic [BW_DEF-1:0] hi_byte(input logic [AW_DEF-1:0] a);
    return a[AW_DEF-1:BW_DEF];
  endfunction

endpackage

// File: rtl/addr_byte_sender.sv
// rtl/addr_byte_sender.sv - sends a 16-bit address onto a byte bus, low byte first with LD strobe
module addr_byte_sender
  import ras_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int BW = BW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr,
  output logic [BW-1:0] bus_out,
  output logic          bus_oe,
  output logic          ld_out,
  output logic          busy
);

  logic [1:0]    state;
  logic [AW-1:0] hold;

  assign busy = (state != IDLE);

  // FSM and registered bus outputs; the first byte is registered on the start edge
  // so it appears in the cycle right after start. The holding register is rotated
  // by one byte as the high byte goes out, which keeps every bit of it live.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hold    <= '0;
      bus_out <= '0;
      bus_oe  <= 1'b0;
      ld_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus_out <= '0;
          bus_oe  <= 1'b0;
          ld_out  <= 1'b0;
          if (start) begin
            hold    <= addr;
            state   <= SEND_LO;
            bus_out <= lo_byte(addr);
            bus_oe  <= 1'b1;
            ld_out  <= 1'b1;
          end
        end
        SEND_LO: begin
          state   <= SEND_HI;
          hold    <= {lo_byte(hold), hi_byte(hold)};
          bus_out <= hi_byte(hold);
          bus_oe  <= 1'b1;
          ld_out  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          bus_out <= '0;
          bus_oe  <= 1'b0;
          ld_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - CALL/RET return-address stack replaying entries onto the PC byte bus
module return_addr_stack
  import ras_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = AW_DEF,
  parameter int BW    = BW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Push,
  input  logic          Pop,
  input  logic [AW-1:0] PCin,
  output logic [BW-1:0] BusOut,
  output logic          BusOE,
  output logic          LDout,
  output logic          Busy,
  output logic          Full,
  output logic          Empty,
  output logic          Err
);

  localparam int AIW = $clog2(DEPTH);
  localparam int SPW = AIW + 1;

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [AIW-1:0] rd_idx;
  logic [AIW-1:0] wr_idx;
  logic           pop_ok;
  logic           push_ok;

  assign Empty  = (sp == '0);
  assign Full   = (sp == SPW'(DEPTH));
  assign rd_idx = AIW'(sp - SPW'(1));

  // A pop needs an idle sender and a non-empty stack; a push needs room,
  // which a same-cycle pop provides by freeing the top slot.
  assign pop_ok  = Pop && !Empty && !Busy;
  assign push_ok = Push && (!Full || pop_ok);
  assign wr_idx  = pop_ok ? rd_idx : sp[AIW-1:0];

  // Stack storage; contents are not reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= PCin;
    end
  end

  // Stack pointer and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      Err <= 1'b0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   sp <= sp + SPW'(1);
        2'b01:   sp <= sp - SPW'(1);
        default: sp <= sp;
      endcase
      if ((Push && !push_ok) || (Pop && !pop_ok)) begin
        Err <= 1'b1;
      end
    end
  end

  addr_byte_sender #(
    .AW(AW),
    .BW(BW)
  ) u_sender (
    .clk    (clk),
    .rst    (rst),
    .start  (pop_ok),
    .addr   (mem[rd_idx]),
    .bus_out(BusOut),
    .bus_oe (BusOE),
    .ld_out (LDout),
    .busy   (Busy)
  );

endmodule
